// File: rtl/perceptron_pkg.sv
// Shared constants, opcodes and FSM states for the perceptron feeder and data stage.
package perceptron_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;

  localparam logic [OPW-1:0] OP_0 = OPW'(0);
  localparam logic [OPW-1:0] OP_1 = OPW'(1);
  localparam logic [OPW-1:0] OP_2 = OPW'(2);
  localparam logic [OPW-1:0] OP_3 = OPW'(3);
  localparam logic [OPW-1:0] OP_4 = OPW'(4);
  localparam logic [OPW-1:0] OP_5 = OPW'(5);
  localparam logic [OPW-1:0] OP_6 = OPW'(6);
  localparam logic [OPW-1:0] OP_7 = OPW'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/percept_serialiser_if.sv
// Producer-side operand handshake for the perceptron serialiser.
interface percept_serialiser_if #(
  parameter int unsigned WIDTH = perceptron_pkg::WIDTH,
  parameter int unsigned OPW   = perceptron_pkg::OPW
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_weight;
  logic [WIDTH-1:0] in_data;
  logic [OPW-1:0]   in_opcode;

  modport master (
    output in_valid,
    output in_weight,
    output in_data,
    output in_opcode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_weight,
    input  in_data,
    input  in_opcode,
    output in_ready
  );

endinterface

// File: rtl/percept_hold_reg.sv
// Single-entry valid/ready holding register for one (weight, data, opcode) triple.
module percept_hold_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_weight,
  input  logic [WIDTH-1:0] s_data,
  input  logic [OPW-1:0]   s_opcode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_weight,
  output logic [WIDTH-1:0] m_data,
  output logic [OPW-1:0]   m_opcode
);

  logic full;

  assign s_ready = !full;
  assign m_valid = full;

  // Capture when empty, release when the consumer pops; both cannot coincide.
  always_ff @(posedge clk) begin
    if (Rst) begin
      full     <= 1'b0;
      m_weight <= '0;
      m_data   <= '0;
      m_opcode <= '0;
    end else if (s_valid && !full) begin
      full     <= 1'b1;
      m_weight <= s_weight;
      m_data   <= s_data;
      m_opcode <= s_opcode;
    end else if (m_ready) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/percept_serialiser.sv
// Serialises (weight, data) operand pairs MSB-first into fixed frames with an idle gap,
// holding the triple's opcode on opcode_out for the whole frame.
module percept_serialiser #(
  parameter int unsigned WIDTH      = perceptron_pkg::WIDTH,
  parameter int unsigned GAP_CYCLES = 5,
  parameter int unsigned OPW        = perceptron_pkg::OPW
) (
  input  logic                clk,
  input  logic                Rst,
  percept_serialiser_if.slave in_if,
  output logic                ser_out,
  output logic [OPW-1:0]      opcode_out,
  output logic                sending,
  output logic                frame_start,
  output logic                frame_done
);

  import perceptron_pkg::*;

  localparam int unsigned FRAME = 2 * WIDTH;
  localparam int unsigned CW    = $clog2(FRAME);
  localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  logic             hold_full;
  logic [WIDTH-1:0] hold_w;
  logic [WIDTH-1:0] hold_d;
  logic [OPW-1:0]   hold_op;

  logic             last_bit_c;
  logic             gap_last_c;
  logic             start_eval_c;
  logic             start_c;
  logic             hold_pop_c;
  logic             hold_in_valid_c;
  logic [WIDTH-1:0] start_w_c;
  logic [WIDTH-1:0] start_d_c;
  logic [OPW-1:0]   start_op_c;
  logic             shreg_msb_unused;

  // The MSB has already been presented on ser_out by the time the shifter moves.
  assign shreg_msb_unused = shreg[FRAME-1];

  // Edges at which a new frame may begin: idle, end of gap, or end of frame with no gap.
  assign last_bit_c   = (state == SHIFT) && (bit_cnt == CW'(FRAME - 1));
  assign gap_last_c   = (state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
  assign start_eval_c = (state == IDLE) || gap_last_c || (last_bit_c && (GAP_CYCLES == 0));

  // Held triple wins; otherwise a fresh transfer goes straight into the shifter.
  assign start_c         = start_eval_c && (hold_full || in_if.in_valid);
  assign hold_pop_c      = start_eval_c && hold_full;
  assign hold_in_valid_c = in_if.in_valid && !start_eval_c;

  // Source of the triple loaded at a frame start.
  assign start_w_c  = hold_full ? hold_w  : in_if.in_weight;
  assign start_d_c  = hold_full ? hold_d  : in_if.in_data;
  assign start_op_c = hold_full ? hold_op : in_if.in_opcode;

  percept_hold_reg #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_hold (
    .clk      (clk),
    .Rst      (Rst),
    .s_valid  (hold_in_valid_c),
    .s_ready  (in_if.in_ready),
    .s_weight (in_if.in_weight),
    .s_data   (in_if.in_data),
    .s_opcode (in_if.in_opcode),
    .m_valid  (hold_full),
    .m_ready  (hold_pop_c),
    .m_weight (hold_w),
    .m_data   (hold_d),
    .m_opcode (hold_op)
  );

  // Frame FSM, shifter, counters and registered downstream outputs.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_out     <= 1'b0;
      opcode_out  <= '0;
      sending     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      case (state)
        SHIFT: begin
          if (!last_bit_c) begin
            shreg   <= {shreg[FRAME-2:0], 1'b0};
            ser_out <= shreg[FRAME-2];
            bit_cnt <= bit_cnt + CW'(1);
          end else begin
            ser_out    <= 1'b0;
            sending    <= 1'b0;
            frame_done <= 1'b1;
            gap_cnt    <= '0;
            state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (!gap_last_c) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: ;
      endcase

      if (start_c) begin
        state       <= SHIFT;
        shreg       <= {start_w_c, start_d_c};
        ser_out     <= start_w_c[WIDTH-1];
        opcode_out  <= start_op_c;
        sending     <= 1'b1;
        frame_start <= 1'b1;
        bit_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_percept_serialiser.sv
// Directed bench for percept_serialiser: default build (gap 5) and a gap-0 build.
module tb_percept_serialiser;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  int         cyc = 0;

  logic       a_ser, a_sending, a_start, a_done;
  logic [2:0] a_opc;
  logic       b_ser, b_sending, b_start, b_done;
  logic [2:0] b_opc;

  percept_serialiser_if a_if ();
  percept_serialiser_if b_if ();

  percept_serialiser dut (
    .clk         (clk),
    .Rst         (Rst),
    .in_if       (a_if.slave),
    .ser_out     (a_ser),
    .opcode_out  (a_opc),
    .sending     (a_sending),
    .frame_start (a_start),
    .frame_done  (a_done)
  );

  percept_serialiser #(.GAP_CYCLES(0)) dut0 (
    .clk         (clk),
    .Rst         (Rst),
    .in_if       (b_if.slave),
    .ser_out     (b_ser),
    .opcode_out  (b_opc),
    .sending     (b_sending),
    .frame_start (b_start),
    .frame_done  (b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] bits;
    logic [2:0]  op;
    int          nb;
    int          st;
  } frame_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] d;
    logic [2:0]  op;
    logic [63:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Observers for build A
  frame_t      a_frames[$];
  int          a_done_q[$];
  logic [63:0] a_bits;
  logic [2:0]  a_fop, a_prev_op;
  bit          a_cap = 1'b0;
  bit          a_rst_prev = 1'b1;
  int          a_nb, a_st;
  int          a_done_cnt = 0, a_start_cnt = 0;
  int          a_glitch = 0, a_idle_bit = 0, a_rdy_err = 0;
  int          a_nacc = 0, a_nstart = 0;

  // Observers for build B
  int           b_start_q[$];
  int           b_done_q[$];
  logic [2:0]   b_op_q[$];
  logic [127:0] b_stream = '0;
  int           b_nb = 0, b_run = 0, b_max_run = 0;

  always @(negedge clk) begin
    #1;
    if (a_done) begin
      a_done_cnt++;
      a_done_q.push_back(cyc);
      if (a_cap) begin
        a_frames.push_back('{bits: a_bits, op: a_fop, nb: a_nb, st: a_st});
        a_cap = 1'b0;
      end
    end
    if (a_cap && !a_sending) a_cap = 1'b0;
    if (a_start) begin
      a_cap = 1'b1; a_bits = '0; a_nb = 0; a_fop = a_opc; a_st = cyc;
      a_start_cnt++;
      a_nstart++;
    end
    if (a_cap && a_sending) begin
      a_bits = {a_bits[62:0], a_ser};
      a_nb++;
      if (a_opc != a_fop) a_glitch++;
    end
    if (!a_sending && a_ser) a_idle_bit++;
    if (!a_rst_prev && (a_opc != a_prev_op) && !a_start) a_glitch++;
    a_prev_op  = a_opc;
    a_rst_prev = Rst;
    // Ready model: ready exactly when no accepted triple is still waiting to start.
    if (Rst) begin
      a_nacc = 0; a_nstart = 0;
    end else begin
      if (a_if.in_ready !== (a_nacc == a_nstart)) a_rdy_err++;
      if (a_if.in_valid && a_if.in_ready) a_nacc++;
    end
  end

  always @(negedge clk) begin
    #1;
    if (b_done) b_done_q.push_back(cyc);
    if (b_start) begin
      b_start_q.push_back(cyc);
      b_op_q.push_back(b_opc);
    end
    if (b_sending && b_nb < 128) begin
      b_stream = {b_stream[126:0], b_ser};
      b_nb++;
    end
    if (b_sending) b_run++; else b_run = 0;
    if (b_run > b_max_run) b_max_run = b_run;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] w,
                       input logic [31:0] d, input logic [2:0] op);
    if (sel) begin
      b_if.in_valid = v; b_if.in_weight = w; b_if.in_data = d; b_if.in_opcode = op;
    end else begin
      a_if.in_valid = v; a_if.in_weight = w; a_if.in_data = d; a_if.in_opcode = op;
    end
  endtask

  // Present a triple from a negedge until accepted; returns the cycle of the accepting edge's setup.
  task automatic push(input bit sel, input logic [31:0] w, input logic [31:0] d,
                      input logic [2:0] op, output int acc);
    bit   ok;
    logic rdy;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 400 && !ok; i++) begin
      drive(sel, 1'b1, w, d, op);
      rdy = sel ? b_if.in_ready : a_if.in_ready;
      if (rdy) begin
        acc = cyc;
        ok  = 1'b1;
      end
      @(negedge clk);
    end
    drive(sel, 1'b0, w, d, op);
    chk("push accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_a_frames(input int n, input int budget);
    for (int i = 0; i < budget && a_frames.size() < n; i++) @(negedge clk);
    chk("frames seen", 64'(a_frames.size()), 64'(n));
  endtask

  function automatic frame_t a_fr(input int i);
    frame_t f;
    f = '{bits: '0, op: '0, nb: 0, st: 0};
    if (i < a_frames.size()) f = a_frames[i];
    return f;
  endfunction

  task automatic chk_frame(input string name, input int idx, input logic [63:0] bits,
                           input logic [2:0] op);
    frame_t f;
    f = a_fr(idx);
    chk({name, " bits"}, f.bits, bits);
    chk({name, " op"}, 64'(f.op), 64'(op));
    chk({name, " len"}, 64'(f.nb), 64'd64);
  endtask

  vec_t vt [9];
  int   acc, acc1, acc3, n0, d0, s0;

  initial begin
    vt[0] = '{w: 32'h000007D0, d: 32'h000003E8, op: 3'd3, exp: 64'h000007D0_000003E8};
    for (int i = 0; i < 8; i++)
      vt[i+1] = '{w: 32'h000007D0, d: 32'h000003E8, op: 3'(i), exp: 64'h000007D0_000003E8};

    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    Rst = 1'b1;
    repeat (3) @(negedge clk);
    Rst = 1'b0;

    // Reset state
    chk("rst ser_out", 64'(a_ser), 64'd0);
    chk("rst opcode_out", 64'(a_opc), 64'd0);
    chk("rst sending", 64'(a_sending), 64'd0);
    chk("rst frame_start", 64'(a_start), 64'd0);
    chk("rst frame_done", 64'(a_done), 64'd0);
    chk("rst in_ready", 64'(a_if.in_ready), 64'd1);
    chk("rst in_ready gap0", 64'(b_if.in_ready), 64'd1);
    repeat (2) @(negedge clk);

    // Single triple from idle, then the eight-opcode stream, all from the vector table
    for (int i = 0; i < 9; i++) push(1'b0, vt[i].w, vt[i].d, vt[i].op, acc);
    wait_a_frames(9, 900);
    for (int i = 0; i < 9; i++) chk_frame($sformatf("vec%0d", i), i, vt[i].exp, vt[i].op);
    chk("single done-start", 64'(a_done_q.size() > 0 ? a_done_q[0] - a_fr(0).st : -1), 64'd64);
    for (int i = 1; i < 8; i++)
      chk($sformatf("spacing %0d", i), 64'(a_fr(i+1).st - a_fr(i).st), 64'd69);

    // Third triple stalls behind a held one
    repeat (10) @(negedge clk);
    n0 = a_frames.size();
    push(1'b0, 32'h1, 32'hD1, 3'd1, acc1);
    push(1'b0, 32'h2, 32'hD2, 3'd2, acc);
    chk("ready low when held", 64'(a_if.in_ready), 64'd0);
    push(1'b0, 32'h3, 32'hD3, 3'd4, acc3);
    wait_a_frames(n0 + 3, 400);
    chk_frame("order w1", n0,     64'h00000001_000000D1, 3'd1);
    chk_frame("order w2", n0 + 1, 64'h00000002_000000D2, 3'd2);
    chk_frame("order w3", n0 + 2, 64'h00000003_000000D3, 3'd4);
    chk("w3 accepted at w2 start", 64'(acc3), 64'(a_fr(n0 + 1).st));
    chk("w2 start after w1", 64'(a_fr(n0 + 1).st - a_fr(n0).st), 64'd69);

    // Gap-0 build: two queued frames with no bubble
    push(1'b1, 32'hFFFFFFFF, 32'h00000000, 3'd5, acc);
    push(1'b1, 32'h00000000, 32'hFFFFFFFF, 3'd6, acc);
    for (int i = 0; i < 300 && b_done_q.size() < 2; i++) @(negedge clk);
    chk("gap0 dones", 64'(b_done_q.size()), 64'd2);
    chk("gap0 starts", 64'(b_start_q.size()), 64'd2);
    chk("gap0 first", b_stream[127:64], 64'hFFFFFFFF_00000000);
    chk("gap0 second", b_stream[63:0], 64'h00000000_FFFFFFFF);
    chk("gap0 contiguous", 64'(b_max_run), 64'd128);
    if (b_done_q.size() >= 1 && b_start_q.size() >= 2) begin
      chk("gap0 done==start", 64'(b_done_q[0]), 64'(b_start_q[1]));
      chk("gap0 period", 64'(b_start_q[1] - b_start_q[0]), 64'd64);
      chk("gap0 op0", 64'(b_op_q[0]), 64'd5);
      chk("gap0 op1", 64'(b_op_q[1]), 64'd6);
    end

    // Reset at bit 20 with a triple held
    repeat (10) @(negedge clk);
    push(1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'd6, acc1);
    push(1'b0, 32'h12345678, 32'h9ABCDEF0, 3'd2, acc);
    for (int i = 0; i < 100 && cyc != acc1 + 21; i++) @(negedge clk);
    chk("at bit 20 sending", 64'(a_sending), 64'd1);
    d0 = a_done_cnt;
    s0 = a_start_cnt;
    n0 = a_frames.size();
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    chk("abort ser_out", 64'(a_ser), 64'd0);
    chk("abort sending", 64'(a_sending), 64'd0);
    chk("abort in_ready", 64'(a_if.in_ready), 64'd1);
    chk("abort opcode_out", 64'(a_opc), 64'd0);
    chk("abort frame_done", 64'(a_done), 64'd0);
    repeat (200) @(negedge clk);
    chk("no done after abort", 64'(a_done_cnt), 64'(d0));
    chk("held never sent", 64'(a_start_cnt), 64'(s0));

    // Valid toggling with ready low must not disturb the queued pair
    n0 = a_frames.size();
    push(1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0, 3'd1, acc);
    push(1'b0, 32'h13579BDF, 32'h2468ACE0, 3'd4, acc);
    chk("toggle ready low", 64'(a_if.in_ready), 64'd0);
    for (int i = 0; i < 30; i++) begin
      if (a_if.in_ready) drive(1'b0, 1'b0, $urandom, $urandom, 3'($urandom));
      else drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom));
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    wait_a_frames(n0 + 2, 300);
    repeat (150) @(negedge clk);
    chk("toggle frame count", 64'(a_frames.size()), 64'(n0 + 2));
    chk_frame("toggle X", n0,     64'h0F0F0F0F_F0F0F0F0, 3'd1);
    chk_frame("toggle Y", n0 + 1, 64'h13579BDF_2468ACE0, 3'd4);

    // Continuous observations over the whole run
    chk("in_ready model errors", 64'(a_rdy_err), 64'd0);
    chk("opcode changes off frame_start", 64'(a_glitch), 64'd0);
    chk("ser_out high while idle", 64'(a_idle_bit), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/percept_serialiser.md
Name: percept_serialiser

Overview:
- Upstream feeder for the perceptron data stage.
- Accepts parallel (weight, data, opcode) operand triples over a valid/ready handshake.
- Shifts each triple out as a 64-bit serial frame, one bit per clk: weight[31:0] MSB-first, then data[31:0] MSB-first.
- Holds opcode stable on the downstream opcode bus for the whole frame. A one-entry holding register lets the producer queue the next triple while the current frame shifts.

Parameters:
- WIDTH, 32: bits per operand; frame length is 2*WIDTH.
- GAP_CYCLES, 5: idle cycles (ser_out=0) inserted after each frame before the next frame starts. 0 is legal and gives back-to-back frames.
- OPW, 3: opcode width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a triple on in_weight/in_data/in_opcode.
- in_ready  out  1  block can take a triple this cycle.
- in_weight  in  WIDTH  weight operand.
- in_data  in  WIDTH  data operand.
- in_opcode  in  OPW  operation for this triple.
- ser_out  out  1  serial bit to the downstream stage's rx input.
- opcode_out  out  OPW  opcode to the downstream stage's opcode input.
- sending  out  1  high during the 2*WIDTH bit cycles of a frame.
- frame_start  out  1  one-cycle pulse coincident with the first bit (weight MSB).
- frame_done  out  1  one-cycle pulse in the cycle after the last bit (data LSB).

Behaviour:
- Reset (Rst=1 at a clk edge):
  - Outputs: ser_out=0, opcode_out=0, sending=0, frame_start=0, frame_done=0, in_ready=1.
  - Internal: shift register=0, bit counter=0, gap counter=0, hold register cleared, state=IDLE.
  - Reset mid-frame aborts the frame immediately with no done pulse, and discards any held triple.
- Handshake:
  - A transfer occurs at an edge where in_valid=1 and in_ready=1.
  - in_ready = !hold_full. It is combinational from registered state only and never depends on in_valid.
  - Producer inputs may change freely when no transfer occurs.
- Accepted-triple routing:
  - In IDLE, the accepted triple loads directly into the shifter.
  - Otherwise it goes into the hold register and hold_full is set.
- State IDLE (ser_out=0, sending=0):
  - If hold_full, or a transfer occurs, go to SHIFT at that edge and load {weight,data} into the 2*WIDTH shifter.
  - At the same edge: opcode_out <= triple opcode, ser_out <= weight[WIDTH-1], sending<=1, frame_start<=1 for one cycle, bit counter <= 0.
  - The hold register has priority over a new transfer. A new transfer still lands in hold if hold was emptied that edge; in_ready was 1 only when hold was empty.
- State SHIFT:
  - Each edge: shifter shifts left, ser_out <= next MSB, counter increments.
  - The bit loaded at entry is bit 0; bit 2*WIDTH-1 (data[0]) is presented in the cycle after counter reaches 2*WIDTH-2.
  - After that bit's cycle: ser_out<=0, sending<=0, frame_done<=1 for one cycle.
  - Then go to GAP if GAP_CYCLES>0, otherwise behave as IDLE at that same edge. Back-to-back: the next frame's first bit immediately follows data[0] and frame_done coincides with the new frame_start.
- opcode_out:
  - Changes only at a frame-start edge.
  - Otherwise it holds its last value through GAP and IDLE.
- State GAP:
  - ser_out=0 for exactly GAP_CYCLES cycles.
  - Then go to IDLE-equivalent evaluation at the edge ending the gap. A held triple starts with no extra bubble.
- Per-frame latency:
  - From transfer edge in IDLE to first bit: 0 cycles (bit is valid the cycle after the edge).
  - Frame period: 2*WIDTH + GAP_CYCLES cycles.
- Hold full and a frame in flight: in_ready=0; producer stalls; no data is lost or overwritten.

Decomposition:
- Shared package perceptron_pkg:
  - constants WIDTH=32 and OPW=3;
  - opcode localparams (OP_0..OP_7) shared with the data stage;
  - state enumeration IDLE/SHIFT/GAP.
- One sub-module, percept_hold_reg: single-entry valid/ready holding register for (weight, data, opcode). The top holds the FSM, shifter and counters.

Test Plan:
- Reset then single triple (w=2000=0x000007D0, d=1000=0x000003E8, op=3) in IDLE:
  - ser_out shows 0x000007D0 then 0x000003E8 MSB-first over 64 cycles;
  - frame_start on bit 0; frame_done 64 cycles later;
  - opcode_out=3 throughout; then 5 zero gap cycles.
- Eight frames, op 0..7, each w=2000, d=1000, fed as fast as in_ready allows:
  - frames spaced exactly 69 cycles apart;
  - opcode_out steps 0..7 only at frame_start edges;
  - in_ready low whenever hold is full.
- Third triple presented while a frame shifts and one triple is held: in_ready=0 until the held triple moves to the shifter; no triple lost or reordered (check w=1,2,3).
- GAP_CYCLES=0 build, two queued triples (w=0xFFFFFFFF, d=0 then w=0, d=0xFFFFFFFF):
  - 128 contiguous bits with no bubble;
  - frame_done and second frame_start in the same cycle.
- Rst asserted at bit 20 of a frame with a triple held: next cycle ser_out=0, sending=0, in_ready=1, opcode_out=0, no frame_done; the held triple is never transmitted.
- in_valid toggling with in_ready=0 and inputs changing: no transfer recorded; the transmitted stream matches only the handshaken values.
